i2c_txn_arbiter: RTL and testbench
==================================

Name: i2c_txn_arbiter

Overview:
Shares one i2c_master_controller between NREQ requesters, e.g. the sensor-config and display-data paths. Each requester posts a burst descriptor: 7-bit target address, rw, and byte count. The arbiter grants round-robin, feeds bytes to the controller one enable/done cycle at a time, returns read bytes, and enforces an inter-byte gap and a per-byte timeout. It sits between the requesting FSMs and the controller's addr/data_in/enable/rw/data_out/ready/done interface.

Parameters:
NREQ, 4, number of requesters (2..8)
GAP_CYCLES, 15, minimum idle cycles between byte transfers; ready must also be high
TIMEOUT_CYCLES, 4095, maximum cycles from ctl_enable to ctl_done before the burst is aborted
LEN_W, 4, width of each burst length field

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
req_valid  in  NREQ  per-requester burst request, level
req_addr  in  NREQ*7  per-requester target address; slice i = [7i+6:7i]
req_rw  in  NREQ  per-requester direction, 1 = read
req_len  in  NREQ*LEN_W  per-requester byte count
wr_data  in  NREQ*8  per-requester current write byte
grant  out  NREQ  one-hot owner, held for the whole burst
wr_pop  out  NREQ  1-cycle pulse: owner's write byte consumed, present the next one
rd_valid  out  1  1-cycle pulse: rd_data valid for the owner
rd_data  out  8  read byte
txn_done  out  NREQ  1-cycle pulse to the owner at burst end
txn_err  out  NREQ  1-cycle pulse with txn_done when the burst aborted on timeout
busy  out  1  high when not IDLE
ctl_addr  out  7  to controller addr
ctl_data_in  out  8  to controller data_in
ctl_enable  out  1  to controller enable
ctl_rw  out  1  to controller rw
ctl_data_out  in  8  from controller data_out
ctl_ready  in  1  from controller ready
ctl_done  in  1  from controller done

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; round-robin pointer 0; counters 0. A reset mid-burst drops ctl_enable immediately; the burst is lost with no txn_done.
- States: IDLE, LOAD, RUN, GAP, FIN.
- IDLE: if any req_valid, select the first set bit scanning from ptr upward with wrap. Latch the winner's addr, rw, len into owner registers and assert grant next cycle. Go to LOAD. After a grant, ptr = winner+1 mod NREQ.
- len=0: go straight from IDLE to FIN. No bus activity; txn_done still pulses.
- LOAD (1 cycle): ctl_data_in <= owner wr_data (don't-care for reads); ctl_addr/ctl_rw <= latched values; ctl_enable <= 1. Go to RUN.
- RUN: hold ctl_enable and ctl_data_in stable until ctl_done. Per-byte timeout counter runs.
  - On ctl_done: ctl_enable <= 0; remaining <= remaining-1.
  - Write burst: pulse wr_pop[owner].
  - Read burst: rd_data <= ctl_data_out and pulse rd_valid in the same cycle.
  - If remaining was 1, go to FIN, else go to GAP.
- Timeout in RUN: when the counter reaches TIMEOUT_CYCLES with no ctl_done, drop ctl_enable, set the error flag, go to FIN.
- GAP: count cycles. Go to LOAD once count >= GAP_CYCLES and ctl_ready=1. Clear the count on exit.
- FIN (1 cycle): pulse txn_done[owner]; pulse txn_err[owner] if the error flag is set. Clear grant and the flag. Go to IDLE.
- Earliest re-grant is the cycle after FIN.
- req_* changes while granted are ignored. The owner must drop req_valid on txn_done or it re-enters arbitration.
- ctl_done in any state other than RUN is ignored.
- Latency: grant 1 cycle after req_valid seen in IDLE; ctl_enable 1 cycle after grant.
- Counters saturate. remaining is LEN_W bits; no wrap.

Decomposition:
- Shared package i2c_pkg: state encodings, address/data widths (7, 8), default GAP/TIMEOUT constants.
- One sub-module: rr_arbiter (NREQ request vector + pointer -> one-hot grant + index), combinational only.

Test Plan:
- Single write: req0 valid, addr 0x07, len 3, bytes A5,5A,3C; controller model returns done 20 cycles after enable -> three enables with data_in A5,5A,3C in order, 3 wr_pop[0] pulses, gaps >= 15 cycles, txn_done[0] once, txn_err 0.
- Read: req2 rw=1, len 2; model returns 0x11 then 0x22 -> rd_valid twice with rd_data 11 then 22, ctl_rw=1, txn_done[2].
- Contention: req0 and req1 raised in the same cycle, each len 1, both held valid after completion -> grants alternate 0,1,0,1; never two grant bits set.
- Timeout: TIMEOUT_CYCLES=50, model never asserts done -> ctl_enable drops at cycle 50 after enable; txn_done[3] and txn_err[3] pulse together; next requester is then served.
- len=0: req1 len 0 -> grant, txn_done[1] within 3 cycles, ctl_enable never asserted.
- Reset mid-RUN: drive rst=0 while ctl_enable=1 -> ctl_enable and grant 0 asynchronously; after release, IDLE with ptr 0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared constants and state encoding for the I2C transaction arbiter.
package i2c_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int DEF_GAP_CYCLES = 15;
    localparam int DEF_TIMEOUT_CYCLES = 4095;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_GAP,
        ST_FIN
    } txn_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first request at or above ptr, wrapping.
module rr_arbiter
    import i2c_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    any
);

    localparam int IW = $clog2(NREQ);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any && req[(int'(ptr) + k) % NREQ]) begin
                any = 1'b1;
                gnt[(int'(ptr) + k) % NREQ] = 1'b1;
                idx = IW'((int'(ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one I2C master controller between NREQ burst requesters,
// one enable/done byte at a time with inter-byte gap and timeout.
module i2c_txn_arbiter
    import i2c_pkg::*;
#(
    parameter int NREQ           = 4,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int LEN_W          = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*ADDR_W-1:0]  req_addr,
    input  logic [NREQ-1:0]         req_rw,
    input  logic [NREQ*LEN_W-1:0]   req_len,
    input  logic [NREQ*DATA_W-1:0]  wr_data,
    output logic [NREQ-1:0]         grant,
    output logic [NREQ-1:0]         wr_pop,
    output logic                    rd_valid,
    output logic [DATA_W-1:0]       rd_data,
    output logic [NREQ-1:0]         txn_done,
    output logic [NREQ-1:0]         txn_err,
    output logic                    busy,
    output logic [ADDR_W-1:0]       ctl_addr,
    output logic [DATA_W-1:0]       ctl_data_in,
    output logic                    ctl_enable,
    output logic                    ctl_rw,
    input  logic [DATA_W-1:0]       ctl_data_out,
    input  logic                    ctl_ready,
    input  logic                    ctl_done
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 2);

    txn_state_t state, nstate;

    logic [IW-1:0]     ptr;
    logic [IW-1:0]     own;
    logic [ADDR_W-1:0] own_addr;
    logic              own_rw;
    logic [LEN_W-1:0]  remaining;
    logic              err;
    logic [TW-1:0]     tcnt;
    logic [GW-1:0]     gcnt;

    logic [NREQ-1:0]   arb_gnt;
    logic [IW-1:0]     arb_idx;
    logic              arb_any;

    logic [ADDR_W-1:0] sel_addr;
    logic              sel_rw;
    logic [LEN_W-1:0]  sel_len;
    logic [DATA_W-1:0] own_wdata;

    logic start, hit, tmo, go;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req (req_valid),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_comb begin
        sel_addr  = '0;
        sel_rw    = 1'b0;
        sel_len   = '0;
        own_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_idx == IW'(i)) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_rw   = req_rw[i];
                sel_len  = req_len[i*LEN_W +: LEN_W];
            end
            if (own == IW'(i)) begin
                own_wdata = wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        start  = 1'b0;
        hit    = 1'b0;
        tmo    = 1'b0;
        go     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (arb_any) begin
                    start  = 1'b1;
                    nstate = (sel_len == '0) ? ST_FIN : ST_LOAD;
                end
            end
            ST_LOAD: nstate = ST_RUN;
            ST_RUN: begin
                if (ctl_done) begin
                    hit    = 1'b1;
                    nstate = (remaining <= LEN_W'(1)) ? ST_FIN : ST_GAP;
                end else if (tcnt >= TW'(TIMEOUT_CYCLES - 1)) begin
                    tmo    = 1'b1;
                    nstate = ST_FIN;
                end
            end
            ST_GAP: begin
                if (gcnt >= GW'(GAP_CYCLES) && ctl_ready) begin
                    go     = 1'b1;
                    nstate = ST_LOAD;
                end
            end
            ST_FIN:  nstate = ST_IDLE;
            default: nstate = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr         <= '0;
            own         <= '0;
            own_addr    <= '0;
            own_rw      <= 1'b0;
            remaining   <= '0;
            err         <= 1'b0;
            tcnt        <= '0;
            gcnt        <= '0;
            grant       <= '0;
            wr_pop      <= '0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            ctl_addr    <= '0;
            ctl_data_in <= '0;
            ctl_enable  <= 1'b0;
            ctl_rw      <= 1'b0;
        end else begin
            wr_pop   <= '0;
            rd_valid <= 1'b0;
            if (start) begin
                own       <= arb_idx;
                own_addr  <= sel_addr;
                own_rw    <= sel_rw;
                remaining <= sel_len;
                grant     <= arb_gnt;
                ptr       <= (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
            end
            if (state == ST_LOAD) begin
                ctl_data_in <= own_wdata;
                ctl_addr    <= own_addr;
                ctl_rw      <= own_rw;
                ctl_enable  <= 1'b1;
                tcnt        <= '0;
            end
            if (state == ST_RUN) begin
                if (hit) begin
                    ctl_enable <= 1'b0;
                    if (remaining != '0) remaining <= remaining - 1'b1;
                    if (own_rw) begin
                        rd_data  <= ctl_data_out;
                        rd_valid <= 1'b1;
                    end else begin
                        wr_pop <= grant;
                    end
                end else if (tmo) begin
                    ctl_enable <= 1'b0;
                    err        <= 1'b1;
                end else if (tcnt != '1) begin
                    tcnt <= tcnt + 1'b1;
                end
            end
            if (state == ST_GAP) begin
                if (go) begin
                    gcnt <= '0;
                end else if (gcnt != '1) begin
                    gcnt <= gcnt + 1'b1;
                end
            end
            if (state == ST_FIN) begin
                grant <= '0;
                err   <= 1'b0;
            end
        end
    end

    assign busy     = (state != ST_IDLE);
    assign txn_done = (state == ST_FIN) ? grant : '0;
    assign txn_err  = (state == ST_FIN && err) ? grant : '0;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Randomized bench for i2c_txn_arbiter with a burst-level reference
// model of requesters and a behavioural I2C controller.
module tb_i2c_txn_arbiter;

    localparam int NREQ = 4;
    localparam int GAP = 15;
    localparam int TMO = 50;

    typedef struct {
        logic [6:0]       addr;
        logic             rw;
        logic [3:0]       len;
        logic [15:0][7:0] data;
        bit               stall;
    } burst_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*7-1:0] req_addr = '0;
    logic [NREQ-1:0]   req_rw = '0;
    logic [NREQ*4-1:0] req_len = '0;
    logic [NREQ*8-1:0] wr_data = '0;
    logic [NREQ-1:0]   grant, wr_pop, txn_done, txn_err;
    logic              rd_valid, busy, ctl_enable, ctl_rw;
    logic [7:0]        rd_data, ctl_data_in;
    logic [6:0]        ctl_addr;
    logic [7:0]        ctl_data_out = '0;
    logic              ctl_ready = 1'b1;
    logic              ctl_done = 1'b0;

    i2c_txn_arbiter #(
        .NREQ           (NREQ),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO),
        .LEN_W          (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_rw       (req_rw),
        .req_len      (req_len),
        .wr_data      (wr_data),
        .grant        (grant),
        .wr_pop       (wr_pop),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .txn_done     (txn_done),
        .txn_err      (txn_err),
        .busy         (busy),
        .ctl_addr     (ctl_addr),
        .ctl_data_in  (ctl_data_in),
        .ctl_enable   (ctl_enable),
        .ctl_rw       (ctl_rw),
        .ctl_data_out (ctl_data_out),
        .ctl_ready    (ctl_ready),
        .ctl_done     (ctl_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    burst_t q[NREQ][$];
    int byte_idx[NREQ];
    int n_pop[NREQ], n_done[NREQ], n_err[NREQ];
    int n_en = 0, posted = 0, lost = 0;
    int fix_lat = 0;
    logic [7:0] rd_script[$];
    logic [7:0] rd_seen[$];
    int hist[$];

    function automatic int rr_pick(logic [NREQ-1:0] r, int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] oh(int w);
        logic [NREQ-1:0] v;
        v = '0;
        if (w >= 0) v[w] = 1'b1;
        return v;
    endfunction

    function automatic logic [15:0][7:0] rand_data();
        logic [15:0][7:0] d;
        for (int i = 0; i < 16; i++) d[i] = 8'($urandom);
        return d;
    endfunction

    task automatic post(int r, logic [6:0] a, logic rw, int len,
                        logic [15:0][7:0] d, bit stall);
        burst_t b;
        b.addr = a;
        b.rw = rw;
        b.len = 4'(len);
        b.data = d;
        b.stall = stall;
        q[r].push_back(b);
        posted++;
    endtask

    // Reference model state, owned by the monitor process
    int owner = -1;
    burst_t cur;
    int cyc = 0, grant_cyc = 0, fall_cyc = 0;
    int nbytes = 0, burst_en = 0, en_cnt = 0, lat = 1, exp_ptr = 0;
    logic [7:0] exp_rd = '0;
    logic en_prev = 1'b0;
    logic [NREQ-1:0] prev_grant = '0, prev_req = '0;

    initial begin : mon
        int w;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                owner = -1;
                en_prev = 1'b0;
                prev_grant = '0;
                prev_req = '0;
                en_cnt = 0;
                exp_ptr = 0;
                for (int i = 0; i < NREQ; i++) byte_idx[i] = 0;
                req_valid = '0;
                ctl_done = 1'b0;
                continue;
            end
            check("gnt_onehot0", 32'($onehot0(grant)), 1);
            if (grant != '0 && prev_grant == '0) begin
                w = rr_pick(prev_req, exp_ptr);
                check("gnt_win", grant, oh(w));
                if (w >= 0) begin
                    owner = w;
                    cur = q[w][0];
                    grant_cyc = cyc;
                    nbytes = 0;
                    burst_en = 0;
                    hist.push_back(w);
                    exp_ptr = (w + 1) % NREQ;
                end
            end else if (owner >= 0) begin
                check("gnt_hold", grant, oh(owner));
            end
            check("busy", busy, owner >= 0);
            if (ctl_enable && !en_prev) begin
                check("en_owned", owner >= 0, 1);
                if (owner >= 0) begin
                    if (burst_en == 0) check("en_lat", cyc - grant_cyc, 1);
                    else check("gap", cyc - fall_cyc >= GAP, 1);
                    check("addr", ctl_addr, cur.addr);
                    check("rw", ctl_rw, cur.rw);
                    if (!cur.rw)
                        check("wdata", ctl_data_in,
                              cur.data[byte_idx[owner]]);
                end
                en_cnt = 0;
                lat = (fix_lat > 0) ? fix_lat : int'($urandom_range(1, 25));
                burst_en++;
                n_en++;
            end
            if (ctl_enable) en_cnt++;
            if (!ctl_enable && en_prev) begin
                fall_cyc = cyc;
                check("en_len", en_cnt, cur.stall ? TMO : lat);
            end
            if (wr_pop != '0) begin
                check("pop_own", wr_pop, oh(owner));
                check("pop_rw", cur.rw, 0);
                if (owner >= 0) begin
                    byte_idx[owner]++;
                    n_pop[owner]++;
                end
                nbytes++;
            end
            if (rd_valid) begin
                check("rd_data", rd_data, exp_rd);
                check("rd_rw", cur.rw, 1);
                rd_seen.push_back(rd_data);
                nbytes++;
            end
            if (txn_done != '0) begin
                check("done_own", txn_done, oh(owner));
                check("done_err", txn_err, cur.stall ? oh(owner) : '0);
                check("nbytes", nbytes, cur.stall ? 0 : int'(cur.len));
                check("burst_en", burst_en, cur.stall ? 1 : int'(cur.len));
                if (cur.len == 0) check("len0_lat", cyc - grant_cyc <= 3, 1);
                if (owner >= 0) begin
                    n_done[owner]++;
                    if (txn_err != '0) n_err[owner]++;
                    void'(q[owner].pop_front());
                    byte_idx[owner] = 0;
                end
                owner = -1;
            end else begin
                check("err_quiet", txn_err, 0);
            end
            // Behavioural controller: done after lat cycles unless stalled
            ctl_done = 1'b0;
            ctl_data_out = 8'($urandom);
            if (ctl_enable && !cur.stall && en_cnt == lat) begin
                ctl_done = 1'b1;
                if (rd_script.size() > 0) ctl_data_out = rd_script.pop_front();
                exp_rd = ctl_data_out;
            end else if (!ctl_enable && $urandom_range(0, 15) == 0) begin
                ctl_done = 1'b1;
            end
            ctl_ready = ($urandom_range(0, 4) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (q[i].size() > 0) begin
                    req_valid[i] = 1'b1;
                    req_addr[i*7 +: 7] = q[i][0].addr;
                    req_rw[i] = q[i][0].rw;
                    req_len[i*4 +: 4] = q[i][0].len;
                    wr_data[i*8 +: 8] = q[i][0].data[byte_idx[i] % 16];
                end else begin
                    req_valid[i] = 1'b0;
                    req_addr[i*7 +: 7] = 7'($urandom);
                    req_len[i*4 +: 4] = 4'($urandom);
                end
            end
            prev_req = req_valid;
            prev_grant = grant;
            en_prev = ctl_enable;
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(int budget);
        int k;
        bit idle;
        k = 0;
        idle = 1'b0;
        while (!idle && k < budget) begin
            tick(1);
            k++;
            idle = !busy && owner < 0;
            for (int i = 0; i < NREQ; i++) if (q[i].size() > 0) idle = 1'b0;
        end
        if (!idle) check("wait_idle_expired", 0, 1);
    endtask

    task automatic wait_grant(int r, int budget);
        int k;
        k = 0;
        while (!grant[r] && k < budget) begin
            tick(1);
            k++;
        end
        if (!grant[r]) check("wait_grant_expired", r, 99);
    endtask

    initial begin : main
        logic [15:0][7:0] d;
        int h0, p0, e0, r, len, sum;
        for (int i = 0; i < NREQ; i++) begin
            byte_idx[i] = 0;
            n_pop[i] = 0;
            n_done[i] = 0;
            n_err[i] = 0;
        end
        #12;
        check("rst_grant", grant, 0);
        check("rst_en", ctl_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_done", txn_done, 0);
        check("rst_pop", wr_pop, 0);
        check("rst_rdv", rd_valid, 0);
        tick(2);
        rst = 1'b1;
        tick(2);

        // single write burst
        fix_lat = 20;
        d = rand_data();
        d[0] = 8'hA5;
        d[1] = 8'h5A;
        d[2] = 8'h3C;
        e0 = n_en;
        post(0, 7'h07, 1'b0, 3, d, 1'b0);
        wait_idle(500);
        check("wr_en_cnt", n_en - e0, 3);
        check("wr_pops", n_pop[0], 3);
        check("wr_done", n_done[0], 1);
        check("wr_err", n_err[0], 0);

        // read burst
        rd_script = '{8'h11, 8'h22};
        rd_seen.delete();
        post(2, 7'h2C, 1'b1, 2, rand_data(), 1'b0);
        wait_idle(500);
        check("rd_cnt", rd_seen.size(), 2);
        check("rd0", rd_seen.size() > 0 ? rd_seen[0] : 8'h00, 8'h11);
        check("rd1", rd_seen.size() > 1 ? rd_seen[1] : 8'h00, 8'h22);
        check("rd_done", n_done[2], 1);
        fix_lat = 0;

        // contention between 0 and 1, both re-requesting
        h0 = hist.size();
        post(0, 7'h10, 1'b0, 1, rand_data(), 1'b0);
        post(0, 7'h11, 1'b0, 1, rand_data(), 1'b0);
        post(1, 7'h20, 1'b1, 1, rand_data(), 1'b0);
        post(1, 7'h21, 1'b1, 1, rand_data(), 1'b0);
        wait_idle(1000);
        check("cont_n", hist.size() - h0, 4);
        check("cont_g0", hist[h0], 0);
        check("cont_g1", hist[h0 + 1], 1);
        check("cont_g2", hist[h0 + 2], 0);
        check("cont_g3", hist[h0 + 3], 1);

        // timeout on requester 3, then requester 0 is served
        h0 = hist.size();
        post(3, 7'h33, 1'b0, 2, rand_data(), 1'b1);
        wait_grant(3, 50);
        post(0, 7'h44, 1'b0, 1, rand_data(), 1'b0);
        wait_idle(1000);
        check("tmo_done", n_done[3], 1);
        check("tmo_err", n_err[3], 1);
        check("tmo_next", hist.size() > h0 + 1 ? hist[h0 + 1] : -1, 0);

        // zero-length burst
        e0 = n_en;
        p0 = n_done[1];
        post(1, 7'h55, 1'b0, 0, rand_data(), 1'b0);
        wait_idle(100);
        check("len0_en", n_en - e0, 0);
        check("len0_done", n_done[1] - p0, 1);

        // reset mid-RUN, then pointer must restart at 0
        fix_lat = 20;
        post(0, 7'h66, 1'b0, 3, rand_data(), 1'b0);
        for (int k = 0; k < 100 && !ctl_enable; k++) tick(1);
        check("pre_rst_en", ctl_enable, 1);
        tick(1);
        rst = 1'b0;
        #1;
        check("arst_en", ctl_enable, 0);
        check("arst_grant", grant, 0);
        check("arst_busy", busy, 0);
        for (int i = 0; i < NREQ; i++) begin
            lost += q[i].size();
            q[i].delete();
        end
        tick(3);
        rst = 1'b1;
        tick(1);
        fix_lat = 0;
        h0 = hist.size();
        post(1, 7'h01, 1'b0, 1, rand_data(), 1'b0);
        post(0, 7'h02, 1'b0, 1, rand_data(), 1'b0);
        wait_idle(500);
        check("ptr0_first", hist.size() > h0 ? hist[h0] : -1, 0);
        check("ptr0_second", hist.size() > h0 + 1 ? hist[h0 + 1] : -1, 1);

        // randomized traffic
        repeat (40) begin
            r = int'($urandom_range(0, NREQ - 1));
            len = int'($urandom_range(0, 5));
            post(r, 7'($urandom), 1'($urandom), len, rand_data(),
                 $urandom_range(0, 11) == 0);
            tick(int'($urandom_range(1, 60)));
        end
        wait_idle(30000);
        sum = 0;
        for (int i = 0; i < NREQ; i++) sum += n_done[i];
        check("all_done", sum, posted - lost);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
